id_ex_pipe: RTL and testbench
=============================

ID_EX_PIPE -- requirements
Module: id_ex_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of register-data and immediate fields.
REQ-002 SHALL have port clk_i  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst_i  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port stall_i  input  1  hold all stage contents (memory-side stall).
REQ-005 SHALL have port bubble_i  input  1  load-use bubble request from hazard detection; zero control fields.
REQ-006 SHALL have port flush_i  input  1  branch/jump squash of the instruction entering EX.
REQ-007 SHALL have port ctrl_i  input  9  {RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc, ALUOp[1:0], RegDst, Branch} from ID.
REQ-008 SHALL have ports rs_data_i, rt_data_i, imm_i  input  DATA_W each  ID operands and sign-extended immediate.
REQ-009 SHALL have ports rs_i, rt_i, rd_i  input  5 each  ID register numbers.
REQ-010 SHALL have ports ctrl_o (9), rs_data_o, rt_data_o, imm_o (DATA_W), rs_o, rt_o, rd_o (5)  output  registered copies for EX.
REQ-011 SHALL have port mem_read_o  output  1  registered MemRead, fed back to hazard detection; equals ctrl_o[6].
REQ-012 SHALL have port valid_o  output  1  EX slot holds a real instruction.
REQ-013 SHALL have port bubble_cnt_o  output  16  count of inserted bubbles (present only with STALL_CNT_EN).

Function
REQ-014 SHALL update on each rising clk_i with priority: stall_i > flush_i > bubble_i > normal load.
REQ-015 stall_i=1 SHALL hold every register, valid_o, and bubble_cnt_o unchanged, regardless of flush_i/bubble_i.
REQ-016 flush_i=1 (no stall) SHALL load ctrl_o=0, valid_o=0, and all data/register-number fields=0.
REQ-017 bubble_i=1 (no stall, no flush) SHALL load ctrl_o=0 and valid_o=0 while loading data and register-number fields normally, so forwarding compares stay deterministic.
REQ-018 Normal load SHALL capture all inputs with one-cycle latency and set valid_o=1.
REQ-019 mem_read_o SHALL be 0 in any cycle where valid_o=0.
REQ-020 A bubble SHALL never persist more than one cycle per bubble_i assertion; back-to-back bubble_i SHALL insert back-to-back bubbles.
REQ-021 Outputs SHALL be driven only from registers, with no combinational input-to-output path.

Reset
REQ-022 rst_i low SHALL immediately, without clock, clear ctrl_o, all data fields, rs_o/rt_o/rd_o, mem_read_o, valid_o, and bubble_cnt_o to 0.
REQ-023 Reset asserted mid-stall or mid-bubble SHALL override both; the first edge after release SHALL perform a normal priority evaluation.

Configuration
REQ-024 Macro STALL_CNT_EN defined: bubble_cnt_o SHALL increment by 1 on each edge where bubble_i=1, stall_i=0, flush_i=0, and saturate at 16'hFFFF.
REQ-025 Macro STALL_CNT_EN undefined: counter logic and bubble_cnt_o SHALL be absent, with all other behaviour identical.

Verification
REQ-026 Reset, then ctrl_i=9'h1A5, rs_data_i=32'h11, rd_i=5'd3, one edge -> ctrl_o=9'h1A5, rs_data_o=32'h11, rd_o=3, valid_o=1.
REQ-027 Load an instruction with MemRead=1, then bubble_i=1 for one edge -> ctrl_o=0, mem_read_o=0, valid_o=0, rt_o=new rt_i, bubble_cnt_o=1.
REQ-028 stall_i=1 together with flush_i=1 and bubble_i=1 for 3 edges -> all outputs unchanged and bubble_cnt_o unchanged.
REQ-029 flush_i=1 and bubble_i=1 on the same edge -> all fields 0, valid_o=0, bubble_cnt_o not incremented.
REQ-030 Preload the counter near saturation by 65535 bubbles, then 2 more bubbles -> bubble_cnt_o=16'hFFFF.
REQ-031 Assert rst_i=0 between clock edges while valid_o=1 -> all outputs 0 before the next edge.

Source files
------------

// File: rtl/id_ex_pipe.sv
//------------------------------------------------------------------------------
// Module      : id_ex_pipe
// Description : ID/EX pipeline register. Supports stall (hold everything),
//               flush (squash the whole slot) and load-use bubble (squash the
//               control fields but keep the operands). Optional saturating
//               bubble counter enabled by the STALL_CNT_EN macro.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module id_ex_pipe #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              bubble_i,
  input  logic              flush_i,
  input  logic [8:0]        ctrl_i,
  input  logic [DATA_W-1:0] rs_data_i,
  input  logic [DATA_W-1:0] rt_data_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [4:0]        rs_i,
  input  logic [4:0]        rt_i,
  input  logic [4:0]        rd_i,
  output logic [8:0]        ctrl_o,
  output logic [DATA_W-1:0] rs_data_o,
  output logic [DATA_W-1:0] rt_data_o,
  output logic [DATA_W-1:0] imm_o,
  output logic [4:0]        rs_o,
  output logic [4:0]        rt_o,
  output logic [4:0]        rd_o,
  output logic              mem_read_o,
`ifdef STALL_CNT_EN
  output logic [15:0]       bubble_cnt_o,
`endif
  output logic              valid_o
);

  // Index of MemRead inside the control bundle.
  localparam int MEM_READ_BIT = 6;

  // A bubble is only inserted when neither a stall nor a flush takes priority.
  logic do_bubble;
  assign do_bubble = bubble_i && !stall_i && !flush_i;

  // Control fields and valid flag: stall > flush > bubble > normal load.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ctrl_o  <= '0;
      valid_o <= 1'b0;
    end else if (stall_i) begin
      ctrl_o  <= ctrl_o;
      valid_o <= valid_o;
    end else if (flush_i || bubble_i) begin
      ctrl_o  <= '0;
      valid_o <= 1'b0;
    end else begin
      ctrl_o  <= ctrl_i;
      valid_o <= 1'b1;
    end
  end

  // Operand and register-number fields: a bubble still loads them so that
  // downstream forwarding comparisons see defined values; a flush zeroes them.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rs_data_o <= '0;
      rt_data_o <= '0;
      imm_o     <= '0;
      rs_o      <= '0;
      rt_o      <= '0;
      rd_o      <= '0;
    end else if (stall_i) begin
      rs_data_o <= rs_data_o;
      rt_data_o <= rt_data_o;
      imm_o     <= imm_o;
      rs_o      <= rs_o;
      rt_o      <= rt_o;
      rd_o      <= rd_o;
    end else if (flush_i) begin
      rs_data_o <= '0;
      rt_data_o <= '0;
      imm_o     <= '0;
      rs_o      <= '0;
      rt_o      <= '0;
      rd_o      <= '0;
    end else begin
      rs_data_o <= rs_data_i;
      rt_data_o <= rt_data_i;
      imm_o     <= imm_i;
      rs_o      <= rs_i;
      rt_o      <= rt_i;
      rd_o      <= rd_i;
    end
  end

  // MemRead comes straight from the control register; it is zero whenever the
  // slot is invalid because every invalidating path clears the control fields.
  assign mem_read_o = ctrl_o[MEM_READ_BIT];

`ifdef STALL_CNT_EN
  // Saturating count of inserted load-use bubbles.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      bubble_cnt_o <= '0;
    end else if (do_bubble && (bubble_cnt_o != 16'hFFFF)) begin
      bubble_cnt_o <= bubble_cnt_o + 16'd1;
    end
  end
`else
  // Without the counter the bubble qualifier has no consumer.
  logic unused_bubble;
  assign unused_bubble = do_bubble;
`endif

endmodule

`default_nettype wire

// File: tb/tb_id_ex_pipe.sv
//------------------------------------------------------------------------------
// Module      : tb_id_ex_pipe
// Description : Self-checking bench for id_ex_pipe. A reference model predicts
//               the register contents for every driven edge; predictions are
//               queued and compared after the edge. Counter checks are built
//               only when STALL_CNT_EN is defined.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_id_ex_pipe;

  localparam int DW = 32;

  typedef struct {
    logic [8:0]    ctrl;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] imm;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic [4:0]    rd;
    logic          valid;
    logic [15:0]   cnt;
  } exp_t;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          stall_i = 1'b0;
  logic          bubble_i = 1'b0;
  logic          flush_i = 1'b0;
  logic [8:0]    ctrl_i = '0;
  logic [DW-1:0] rs_data_i = '0;
  logic [DW-1:0] rt_data_i = '0;
  logic [DW-1:0] imm_i = '0;
  logic [4:0]    rs_i = '0;
  logic [4:0]    rt_i = '0;
  logic [4:0]    rd_i = '0;
  logic [8:0]    ctrl_o;
  logic [DW-1:0] rs_data_o;
  logic [DW-1:0] rt_data_o;
  logic [DW-1:0] imm_o;
  logic [4:0]    rs_o;
  logic [4:0]    rt_o;
  logic [4:0]    rd_o;
  logic          mem_read_o;
  logic          valid_o;
`ifdef STALL_CNT_EN
  logic [15:0]   bubble_cnt_o;
`endif

  int   n_vec = 0;
  int   n_err = 0;
  exp_t m;
  exp_t sb[$];

  id_ex_pipe #(.DATA_W(DW)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .stall_i     (stall_i),
    .bubble_i    (bubble_i),
    .flush_i     (flush_i),
    .ctrl_i      (ctrl_i),
    .rs_data_i   (rs_data_i),
    .rt_data_i   (rt_data_i),
    .imm_i       (imm_i),
    .rs_i        (rs_i),
    .rt_i        (rt_i),
    .rd_i        (rd_i),
    .ctrl_o      (ctrl_o),
    .rs_data_o   (rs_data_o),
    .rt_data_o   (rt_data_o),
    .imm_o       (imm_o),
    .rs_o        (rs_o),
    .rt_o        (rt_o),
    .rd_o        (rd_o),
    .mem_read_o  (mem_read_o),
`ifdef STALL_CNT_EN
    .bubble_cnt_o(bubble_cnt_o),
`endif
    .valid_o     (valid_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #3000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, ".ctrl"},     DW'(ctrl_o),     DW'(e.ctrl));
    chk({tag, ".rs_data"},  rs_data_o,       e.rs_data);
    chk({tag, ".rt_data"},  rt_data_o,       e.rt_data);
    chk({tag, ".imm"},      imm_o,           e.imm);
    chk({tag, ".rs"},       DW'(rs_o),       DW'(e.rs));
    chk({tag, ".rt"},       DW'(rt_o),       DW'(e.rt));
    chk({tag, ".rd"},       DW'(rd_o),       DW'(e.rd));
    chk({tag, ".valid"},    DW'(valid_o),    DW'(e.valid));
    chk({tag, ".mem_read"}, DW'(mem_read_o), DW'(e.valid & e.ctrl[6]));
`ifdef STALL_CNT_EN
    chk({tag, ".cnt"},      DW'(bubble_cnt_o), DW'(e.cnt));
`endif
  endtask

  task automatic model_reset();
    m = '{ctrl: '0, rs_data: '0, rt_data: '0, imm: '0, rs: '0, rt: '0, rd: '0,
          valid: 1'b0, cnt: '0};
  endtask

  // Drive one edge worth of stimulus, predict, and check after the edge.
  task automatic step(input string tag, input bit st, input bit fl, input bit bu,
                      input logic [8:0] c, input logic [DW-1:0] rsd,
                      input logic [DW-1:0] rtd, input logic [DW-1:0] im,
                      input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    exp_t e;
    stall_i = st; flush_i = fl; bubble_i = bu;
    ctrl_i = c; rs_data_i = rsd; rt_data_i = rtd; imm_i = im;
    rs_i = rs; rt_i = rt; rd_i = rd;
    if (st) begin
      // hold
    end else if (fl) begin
      m.ctrl = '0; m.rs_data = '0; m.rt_data = '0; m.imm = '0;
      m.rs = '0; m.rt = '0; m.rd = '0; m.valid = 1'b0;
    end else begin
      m.rs_data = rsd; m.rt_data = rtd; m.imm = im;
      m.rs = rs; m.rt = rt; m.rd = rd;
      if (bu) begin
        m.ctrl = '0; m.valid = 1'b0;
        if (m.cnt != 16'hFFFF) m.cnt = m.cnt + 16'd1;
      end else begin
        m.ctrl = c; m.valid = 1'b1;
      end
    end
    sb.push_back(m);
    @(posedge clk_i);
    #1;
    e = sb.pop_front();
    chk_all(tag, e);
  endtask

  task automatic step_rand(input string tag, input bit st, input bit fl, input bit bu);
    step(tag, st, fl, bu, 9'($urandom), $urandom, $urandom, $urandom,
         5'($urandom), 5'($urandom), 5'($urandom));
  endtask

  initial begin
    model_reset();
    // Reset state while held in reset.
    #2;
    chk_all("reset", m);
    @(negedge clk_i);
    rst_i = 1'b1;

    // Basic load.
    step("load_1a5", 0, 0, 0, 9'h1A5, 32'h11, 32'h0, 32'h0, 5'd0, 5'd0, 5'd3);

    // Load with MemRead, then a load-use bubble with a new rt.
    step("load_memrd", 0, 0, 0, 9'h140, 32'hA, 32'hB, 32'hC, 5'd1, 5'd2, 5'd4);
    step("bubble", 0, 0, 1, 9'h1FF, 32'hD, 32'hE, 32'hF, 5'd5, 5'd9, 5'd7);

    // Normal load then stall with flush and bubble for three edges.
    step_rand("load_pre_stall", 0, 0, 0);
    for (int i = 0; i < 3; i++) step_rand("stall_all", 1, 1, 1);

    // Flush and bubble together.
    step_rand("flush_bubble", 0, 1, 1);

    // Back-to-back bubbles and a mix of patterns.
    step_rand("load_a", 0, 0, 0);
    step_rand("bubble_b2b_1", 0, 0, 1);
    step_rand("bubble_b2b_2", 0, 0, 1);
    step_rand("load_b", 0, 0, 0);
    step_rand("flush_only", 0, 1, 0);
    step_rand("load_c", 0, 0, 0);
    step_rand("stall_bubble", 1, 0, 1);
    step_rand("load_d", 0, 0, 0);

    // Asynchronous reset between edges while valid, asserted during a stall.
    #2;
    stall_i = 1'b1; bubble_i = 1'b1;
    rst_i = 1'b0;
    #1;
    model_reset();
    chk_all("async_rst", m);
    @(negedge clk_i);
    rst_i = 1'b1;
    step_rand("post_rst_load", 0, 0, 0);

`ifdef STALL_CNT_EN
    // Drive the counter into saturation.
    for (int i = 0; i < 65537; i++) step_rand("sat_fill", 0, 0, 1);
    step_rand("sat_hold", 0, 0, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
